// File: rtl/variable_pkg.sv
// Shared video timing types, default 800x600@60 (40 MHz) mode values and a
// parameter sanity helper.
package variable_pkg;

  // One axis of a video mode; all values are inclusive positions.
  typedef struct packed {
    logic [15:0] blank_start;
    logic [15:0] sync_start;
    logic [15:0] sync_end;
    logic [15:0] blank_end;
  } timing_t;

  localparam timing_t SVGA_H = '{
    blank_start: 16'd800,
    sync_start:  16'd840,
    sync_end:    16'd967,
    blank_end:   16'd1055
  };

  localparam timing_t SVGA_V = '{
    blank_start: 16'd600,
    sync_start:  16'd601,
    sync_end:    16'd604,
    blank_end:   16'd627
  };

  localparam int unsigned SVGA_CNT_W = 11;

  // True when the axis is ordered correctly and fits in a cnt_w-bit counter.
  function automatic logic timing_ok(int unsigned bs, int unsigned ss,
                                     int unsigned se, int unsigned be,
                                     int unsigned cnt_w);
    return (bs < ss) && (ss <= se) && (se <= be) && ((be >> cnt_w) == 0);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-enable in, counters/sync/blank/strobes out.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 11
);
  logic             pix_en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic             active;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  pix_en,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, active,
           line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, active,
           line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen_wrap_counter.sv
// Enabled modulo-(MAX+1) counter with a registered strobe marking the cycle
// in which the count has just wrapped to zero.
module wrap_counter #(
  parameter int unsigned CNT_W = 11,
  parameter int unsigned MAX   = 1055
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

  // Count on enable; wrap only on the equality compare, strobe for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= en && (cnt == CNT_MAX);
      if (en) begin
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: column/line counters with sync, blanking, active
// and line/frame strobes, all registered and aligned with the counts.
module vga_timing_gen
  import variable_pkg::*;
#(
  parameter int unsigned H_BLANK_START = 32'(SVGA_H.blank_start),
  parameter int unsigned H_SYNC_START  = 32'(SVGA_H.sync_start),
  parameter int unsigned H_SYNC_END    = 32'(SVGA_H.sync_end),
  parameter int unsigned H_BLANK_END   = 32'(SVGA_H.blank_end),
  parameter int unsigned V_BLANK_START = 32'(SVGA_V.blank_start),
  parameter int unsigned V_SYNC_START  = 32'(SVGA_V.sync_start),
  parameter int unsigned V_SYNC_END    = 32'(SVGA_V.sync_end),
  parameter int unsigned V_BLANK_END   = 32'(SVGA_V.blank_end),
  parameter logic        HSYNC_POL     = 1'b1,
  parameter logic        VSYNC_POL     = 1'b1,
  parameter int unsigned CNT_W         = SVGA_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vif
);

  // Reject inconsistent timing or an undersized counter at elaboration.
  if (!timing_ok(H_BLANK_START, H_SYNC_START, H_SYNC_END, H_BLANK_END, CNT_W))
  begin : g_bad_h_timing
    $error("vga_timing_gen: invalid horizontal timing parameters");
  end
  if (!timing_ok(V_BLANK_START, V_SYNC_START, V_SYNC_END, V_BLANK_END, CNT_W))
  begin : g_bad_v_timing
    $error("vga_timing_gen: invalid vertical timing parameters");
  end

  localparam logic [CNT_W-1:0] H_BS = CNT_W'(H_BLANK_START);
  localparam logic [CNT_W-1:0] H_SS = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] H_SE = CNT_W'(H_SYNC_END);
  localparam logic [CNT_W-1:0] H_BE = CNT_W'(H_BLANK_END);
  localparam logic [CNT_W-1:0] V_BS = CNT_W'(V_BLANK_START);
  localparam logic [CNT_W-1:0] V_SS = CNT_W'(V_SYNC_START);
  localparam logic [CNT_W-1:0] V_SE = CNT_W'(V_SYNC_END);
  localparam logic [CNT_W-1:0] V_BE = CNT_W'(V_BLANK_END);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_last;
  logic             v_en;
  logic             h_wrap;
  logic             v_wrap;

  assign h_last = (h_cnt == H_BE);
  assign v_en   = vif.pix_en && h_last;

  wrap_counter #(
    .CNT_W (CNT_W),
    .MAX   (H_BLANK_END)
  ) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (vif.pix_en),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  wrap_counter #(
    .CNT_W (CNT_W),
    .MAX   (V_BLANK_END)
  ) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (v_en),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  // Next-state counts, so decoded flags land in the same cycle as the counts.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (vif.pix_en) begin
      h_nxt = h_last ? '0 : h_cnt + CNT_W'(1);
    end
    if (v_en) begin
      v_nxt = (v_cnt == V_BE) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  // Registered sync/blank/active decode of the next position.
  always_ff @(posedge clk) begin
    if (rst) begin
      vif.hblnk  <= 1'b0;
      vif.vblnk  <= 1'b0;
      vif.active <= 1'b1;
      vif.hsync  <= ~HSYNC_POL;
      vif.vsync  <= ~VSYNC_POL;
    end else begin
      vif.hblnk  <= (h_nxt >= H_BS);
      vif.vblnk  <= (v_nxt >= V_BS);
      vif.active <= (h_nxt < H_BS) && (v_nxt < V_BS);
      vif.hsync  <= ((h_nxt >= H_SS) && (h_nxt <= H_SE)) ? HSYNC_POL : ~HSYNC_POL;
      vif.vsync  <= ((v_nxt >= V_SS) && (v_nxt <= V_SE)) ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign vif.hcount      = h_cnt;
  assign vif.vcount      = v_cnt;
  assign vif.line_start  = h_wrap;
  assign vif.frame_start = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default SVGA mode, 640x480 with inverted hsync,
// and a tiny mode short enough to cover whole frames.
module tb_vga_timing_gen;
  import variable_pkg::*;

  typedef struct {
    int hb, hs, he, hend;
    int vb, vs, ve, vend;
    bit hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic [6:0]  f;   // hsync vsync hblnk vblnk active line_start frame_start
  } obs_t;

  typedef struct {
    bit rst;
    bit en;
    int reps;
    int h;
    int v;
    bit ls;
    bit fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(11)) if_a ();
  vga_timing_gen_if #(.CNT_W(10)) if_b ();
  vga_timing_gen_if #(.CNT_W(4))  if_c ();

  assign if_a.pix_en = pix_en;
  assign if_b.pix_en = pix_en;
  assign if_c.pix_en = pix_en;

  vga_timing_gen #(
    .H_BLANK_START (32'(SVGA_H.blank_start)),
    .H_SYNC_START  (32'(SVGA_H.sync_start)),
    .H_SYNC_END    (32'(SVGA_H.sync_end)),
    .H_BLANK_END   (32'(SVGA_H.blank_end)),
    .V_BLANK_START (32'(SVGA_V.blank_start)),
    .V_SYNC_START  (32'(SVGA_V.sync_start)),
    .V_SYNC_END    (32'(SVGA_V.sync_end)),
    .V_BLANK_END   (32'(SVGA_V.blank_end)),
    .HSYNC_POL     (1'b1),
    .VSYNC_POL     (1'b1),
    .CNT_W         (SVGA_CNT_W)
  ) dut_a (.clk(clk), .rst(rst), .vif(if_a));

  vga_timing_gen #(
    .H_BLANK_START (640), .H_SYNC_START (656), .H_SYNC_END (751), .H_BLANK_END (799),
    .V_BLANK_START (480), .V_SYNC_START (490), .V_SYNC_END (491), .V_BLANK_END (524),
    .HSYNC_POL     (1'b0), .VSYNC_POL (1'b1), .CNT_W (10)
  ) dut_b (.clk(clk), .rst(rst), .vif(if_b));

  vga_timing_gen #(
    .H_BLANK_START (8), .H_SYNC_START (10), .H_SYNC_END (12), .H_BLANK_END (15),
    .V_BLANK_START (4), .V_SYNC_START (5),  .V_SYNC_END (6),  .V_BLANK_END (9),
    .HSYNC_POL     (1'b1), .VSYNC_POL (1'b1), .CNT_W (4)
  ) dut_c (.clk(clk), .rst(rst), .vif(if_c));

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {16'(if_a.hcount), 16'(if_a.vcount), if_a.hsync, if_a.vsync, if_a.hblnk,
                  if_a.vblnk, if_a.active, if_a.line_start, if_a.frame_start};
  assign obs_b = {16'(if_b.hcount), 16'(if_b.vcount), if_b.hsync, if_b.vsync, if_b.hblnk,
                  if_b.vblnk, if_b.active, if_b.line_start, if_b.frame_start};
  assign obs_c = {16'(if_c.hcount), 16'(if_c.vcount), if_c.hsync, if_c.vsync, if_c.hblnk,
                  if_c.vblnk, if_c.active, if_c.line_start, if_c.frame_start};

  cfg_t  cfg_a, cfg_b, cfg_c;
  int    checks = 0;
  int    errors = 0;
  longint n = 0;          // enabled pixel clocks since the last reset
  bit    stepped = 1'b0;  // last edge advanced the position

  // Edge bookkeeping for sync/blank checks
  int a_hs_rise = -1, a_hs_fall = -1, a_hb_rise = -1;
  int c_vs_rise = -1, c_vs_fall = -1, c_vb_rise = -1;
  int b_lo = 99999, b_hi = -1, b_max = -1;
  bit a_hs_q = 1'b0, a_hb_q = 1'b0, c_vs_q = 1'b0, c_vb_q = 1'b0;

  // Expected outputs from the raster position implied by n enabled pixels.
  function automatic obs_t model(cfg_t c, longint cnt, bit stp);
    obs_t   o;
    longint ht = longint'(c.hend) + 1;
    longint vt = longint'(c.vend) + 1;
    longint h  = cnt % ht;
    longint v  = (cnt / ht) % vt;
    bit hb, vb, hs, vs, ls, fs;
    hb = (h >= c.hb);
    vb = (v >= c.vb);
    hs = (h >= c.hs && h <= c.he) ? c.hpol : !c.hpol;
    vs = (v >= c.vs && v <= c.ve) ? c.vpol : !c.vpol;
    ls = stp && (cnt > 0) && (h == 0);
    fs = stp && (cnt > 0) && ((cnt % (ht * vt)) == 0);
    o.h = 16'(h);
    o.v = 16'(v);
    o.f = {hs, vs, hb, vb, !(hb || vb), ls, fs};
    return o;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d: got h=%0d v=%0d flags=%b, expected h=%0d v=%0d flags=%b",
               name, n, act.h, act.v, act.f, exp.h, exp.v, exp.f);
    end
  endtask

  // One clock: advance the reference position, record edges, compare all DUTs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      n = 0;
      stepped = 1'b0;
    end else if (pix_en) begin
      n++;
      stepped = 1'b1;
    end else begin
      stepped = 1'b0;
    end
    if (if_a.hsync && !a_hs_q) a_hs_rise = int'(if_a.hcount);
    if (!if_a.hsync && a_hs_q) a_hs_fall = int'(if_a.hcount);
    if (if_a.hblnk && !a_hb_q) a_hb_rise = int'(if_a.hcount);
    if (if_c.vsync && !c_vs_q) c_vs_rise = int'(if_c.vcount);
    if (!if_c.vsync && c_vs_q) c_vs_fall = int'(if_c.vcount);
    if (if_c.vblnk && !c_vb_q) c_vb_rise = int'(if_c.vcount);
    a_hs_q = if_a.hsync;
    a_hb_q = if_a.hblnk;
    c_vs_q = if_c.vsync;
    c_vb_q = if_c.vblnk;
    if (!if_b.hsync) begin
      if (int'(if_b.hcount) < b_lo) b_lo = int'(if_b.hcount);
      if (int'(if_b.hcount) > b_hi) b_hi = int'(if_b.hcount);
    end
    if (int'(if_b.hcount) > b_max) b_max = int'(if_b.hcount);
    check_obs("model_a", obs_a, model(cfg_a, n, stepped));
    check_obs("model_b", obs_b, model(cfg_b, n, stepped));
    check_obs("model_c", obs_c, model(cfg_c, n, stepped));
  endtask

  vec_t tbl[13];

  initial begin
    longint last_fs;
    int     frames;

    cfg_a = '{800, 840, 967, 1055, 600, 601, 604, 627, 1'b1, 1'b1};
    cfg_b = '{640, 656, 751, 799, 480, 490, 491, 524, 1'b0, 1'b1};
    cfg_c = '{8, 10, 12, 15, 4, 5, 6, 9, 1'b1, 1'b1};

    //        rst  en  reps   h     v  ls fs
    tbl[0]  = '{1, 1,    3,    0,   0, 0, 0};  // reset with pix_en high
    tbl[1]  = '{0, 1,    1,    1,   0, 0, 0};  // first step lands on (1,0)
    tbl[2]  = '{0, 1,   99,  100,   0, 0, 0};
    tbl[3]  = '{0, 1,    1,  101,   0, 0, 0};  // enable gating 1,0,0,1
    tbl[4]  = '{0, 0,    1,  101,   0, 0, 0};
    tbl[5]  = '{0, 0,    1,  101,   0, 0, 0};
    tbl[6]  = '{0, 1,    1,  102,   0, 0, 0};
    tbl[7]  = '{0, 1,  953, 1055,   0, 0, 0};
    tbl[8]  = '{0, 1,    1,    0,   1, 1, 0};  // line wrap strobe
    tbl[9]  = '{0, 1,    1,    1,   1, 0, 0};  // strobe lasts one cycle
    tbl[10] = '{0, 1,   49,   50,   1, 0, 0};
    tbl[11] = '{1, 1,    1,    0,   0, 0, 0};  // mid-line reset
    tbl[12] = '{1, 0,    2,    0,   0, 0, 0};  // reset ignores pix_en

    rst    = 1'b1;
    pix_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      rst    = tbl[i].rst;
      pix_en = tbl[i].en;
      repeat (tbl[i].reps) tick();
      chk($sformatf("tbl%0d_hcount", i), longint'(if_a.hcount), tbl[i].h);
      chk($sformatf("tbl%0d_vcount", i), longint'(if_a.vcount), tbl[i].v);
      chk($sformatf("tbl%0d_line_start", i), longint'(if_a.line_start), longint'(tbl[i].ls));
      chk($sformatf("tbl%0d_frame_start", i), longint'(if_a.frame_start), longint'(tbl[i].fs));
      if (i == 0) begin
        chk("rst_hsync", longint'(if_a.hsync), 0);
        chk("rst_vsync", longint'(if_a.vsync), 0);
        chk("rst_active", longint'(if_a.active), 1);
      end
    end

    // Line wrap from (1055, 5) on the default mode
    rst = 1'b0;
    pix_en = 1'b1;
    repeat (5 * 1056 + 1055) tick();
    chk("lw_pre_h", longint'(if_a.hcount), 1055);
    chk("lw_pre_v", longint'(if_a.vcount), 5);
    tick();
    chk("lw_h", longint'(if_a.hcount), 0);
    chk("lw_v", longint'(if_a.vcount), 6);
    chk("lw_line_start", longint'(if_a.line_start), 1);
    chk("lw_frame_start", longint'(if_a.frame_start), 0);
    tick();
    chk("lw_line_start_clear", longint'(if_a.line_start), 0);
    chk("hsync_rise_at", a_hs_rise, 840);
    chk("hsync_fall_at", a_hs_fall, 968);
    chk("hblnk_rise_at", a_hb_rise, 800);

    // Whole frames on the small mode with random enable gaps
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_fs = -1;
    frames = 0;
    for (int i = 0; i < 700; i++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      tick();
      if (if_c.frame_start) begin
        chk("fs_with_line_start", longint'(if_c.line_start), 1);
        chk("fs_at_origin", longint'({if_c.hcount, if_c.vcount}), 0);
        if (last_fs < 0) chk("first_frame_n", n, 160);
        else chk("frame_period", n - last_fs, 160);
        last_fs = n;
        frames++;
        pix_en = 1'b1;
        tick();
        chk("fs_one_cycle", longint'(if_c.frame_start), 0);
      end
    end
    chk("frames_seen_ge2", longint'(frames >= 2), 1);
    chk("c_vsync_rise_at", c_vs_rise, 5);
    chk("c_vsync_fall_at", c_vs_fall, 7);
    chk("c_vblnk_rise_at", c_vb_rise, 4);

    // Random enable and occasional reset against the reference model
    for (int i = 0; i < 4000; i++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    chk("b_hsync_low_first", b_lo, 656);
    chk("b_hsync_low_last", b_hi, 751);
    chk("b_hcount_max", b_max, 799);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
